ysyx_24100006_flush_ctrl: RTL and testbench
===========================================

// Module: ysyx_24100006_flush_ctrl
// PURPOSE
// - Generates the flush_i / redirect stream consumed by the IF_ID and ID_EXE pipeline registers and the IFU.
// - EXEU issues one redirect request (jump/branch taken, trap/irq, mret, fence.i) per valid/ready handshake.
// - The block squashes younger stages, drains the LSU and flushes the I-cache for fence.i.
// - It then hands the new PC to the IFU over a valid/ready handshake.
// PARAMETERS
// - PC_W            32  width of PCs and redirect target
// - ICACHE_FLUSH_EN 1   1: fence.i runs the I-cache flush handshake; 0: ICFLUSH state skipped
// - CNT_W           32  width of the flush event counter
// PORTS
// - clk                 in   1     clock
// - reset               in   1     asynchronous, active-high reset
// - exe_redir_valid     in   1     EXEU requests redirect
// - exe_redir_ready     out  1     request accepted this cycle when valid&&ready
// - exe_redir_kind      in   2     0 jump/branch, 1 trap/irq, 2 mret, 3 fence.i
// - exe_redir_pc        in   PC_W  target PC (fence.i: pc+4; trap: mtvec; mret: mepc)
// - lsu_idle            in   1     no outstanding load/store on the bus
// - icache_flush_req    out  1     I-cache invalidate request, held until done
// - icache_flush_done   in   1     one-cycle completion pulse from I-cache
// - flush_if_id         out  1     squash IF_ID register (drives its flush_i)
// - flush_id_exe        out  1     squash ID_EXE register (drives its flush_i)
// - redir_valid         out  1     new PC available to IFU
// - redir_ready         in   1     IFU accepts redir_pc
// - redir_pc            out  PC_W  registered redirect target
// - busy                out  1     state != IDLE
// - flush_count         out  CNT_W number of completed redirects
// BEHAVIOUR
// - States: IDLE, DRAIN, ICFLUSH, REDIR. On reset, the state is IDLE and every output is 0, except exe_redir_ready=1.
// - exe_redir_ready = (state==IDLE). Accept = exe_redir_valid && exe_redir_ready (cycle T).
//   - At T, exe_redir_pc and exe_redir_kind are latched.
// - flush_if_id = flush_id_exe = accept || (state!=IDLE). Both are combinational in T, so the receiving register gates out_valid the same cycle.
//   - Both stay high through the cycle in which redir_valid&&redir_ready, inclusive.
// - IDLE -> accept:
//   - kind 0/1/2 -> REDIR.
//   - kind 3 -> DRAIN.
// - DRAIN: wait for lsu_idle=1.
//   - -> ICFLUSH if ICACHE_FLUSH_EN, else -> REDIR. This is evaluated in the cycle after lsu_idle is sampled high.
// - ICFLUSH:
//   - icache_flush_req=1 in every ICFLUSH cycle.
//   - On icache_flush_done -> REDIR; req drops the next cycle.
// - REDIR:
//   - redir_valid=1. redir_pc is held stable until redir_ready.
//   - On handshake -> IDLE, and flush_count += 1 (wraps modulo 2^CNT_W).
// - Latency for kind 0/1/2 with redir_ready=1: flush at T and T+1, redir_valid at T+1, IDLE at T+2.
// - With redir_ready low, REDIR holds indefinitely. No new request is accepted (ready=0) and flushes stay asserted.
// - exe_redir_valid while busy is ignored. EXEU must hold it per the valid/ready rule.
// - icache_flush_done outside ICFLUSH is ignored. lsu_idle already 1 on entry to DRAIN costs 1 DRAIN cycle.
// - Async reset in any state goes to IDLE immediately. Any in-flight redirect is dropped, icache_flush_req deasserts, and flush_count clears.
// STRUCTURE
// - Shared package: redirect kind encodings (KIND_JUMP/TRAP/MRET/FENCEI) and state encoding localparams.
// - Single module; no sub-module. FSM plus a target register and a counter.
// TESTING
// - Jump case:
//   - Stimulus: kind0, pc=0x8000_0100, redir_ready=1.
//   - Expect: flushes high T,T+1; redir_valid T+1 with pc 0x8000_0100; busy low T+2; flush_count=1.
// - Backpressure case:
//   - Stimulus: kind1 (trap) to 0x8000_0004 with redir_ready low 3 cycles.
//   - Expect: redir_pc stable; exe_redir_ready=0 and flushes=1 throughout; done on the 4th cycle.
// - fence.i case:
//   - Stimulus: kind3, pc=0x8000_0010, lsu_idle=0 for 4 cycles, done pulse 2 cycles after req.
//   - Expect: DRAIN 4+1 cycles, req high for 2 cycles then REDIR to 0x8000_0010.
// - ICACHE_FLUSH_EN=0 case:
//   - Stimulus: kind3 with lsu_idle=1.
//   - Expect: icache_flush_req never rises; redir_valid at T+2.
// - Busy case:
//   - Stimulus: a second request (kind2, 0x8000_0200) while busy.
//   - Expect: not accepted until IDLE, then serviced normally; flush_count increments by 2 in total.
// - Reset case:
//   - Stimulus: reset asserted mid-ICFLUSH.
//   - Expect: all outputs 0 at once (ready=1); flush_count=0; a subsequent done pulse is ignored.

Source files
------------

// File: rtl/ysyx_24100006_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_flush_ctrl_pkg
// Shared definitions for the pipeline flush / redirect controller:
//   - redirect kind encodings driven by EXEU on exe_redir_kind
//   - FSM state encoding used by the controller
// ---------------------------------------------------------------------------
package ysyx_24100006_flush_ctrl_pkg;

    // Redirect request kinds issued by EXEU
    localparam logic [1:0] KIND_JUMP   = 2'd0;  // jump / branch taken
    localparam logic [1:0] KIND_TRAP   = 2'd1;  // trap / interrupt, target is mtvec
    localparam logic [1:0] KIND_MRET   = 2'd2;  // mret, target is mepc
    localparam logic [1:0] KIND_FENCEI = 2'd3;  // fence.i, target is pc+4

    // Controller states
    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_DRAIN_ENC   = 2'd1;
    localparam logic [1:0] ST_ICFLUSH_ENC = 2'd2;
    localparam logic [1:0] ST_REDIR_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_DRAIN   = ST_DRAIN_ENC,
        ST_ICFLUSH = ST_ICFLUSH_ENC,
        ST_REDIR   = ST_REDIR_ENC
    } flush_state_t;

endpackage

// File: rtl/ysyx_24100006_flush_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_flush_ctrl
// Turns one EXEU redirect request into the flush / redirect sequence:
// squash IF_ID and ID_EXE, optionally drain the LSU and flush the I-cache
// (fence.i), then hand the new PC to the IFU over a valid/ready handshake.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   exe_redir_valid/ready/kind/pc   request channel from EXEU
//   lsu_idle             LSU has no outstanding bus access
//   icache_flush_req/done           I-cache invalidate handshake
//   flush_if_id, flush_id_exe       squash strobes for the pipeline registers
//   redir_valid/ready/pc            new-PC channel to the IFU
//   busy                 controller is not idle
//   flush_count          completed redirects (wraps)
// ---------------------------------------------------------------------------
module ysyx_24100006_flush_ctrl
    import ysyx_24100006_flush_ctrl_pkg::*;
#(
    parameter int PC_W            = 32,
    parameter bit ICACHE_FLUSH_EN = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exe_redir_valid,
    output logic             exe_redir_ready,
    input  logic [1:0]       exe_redir_kind,
    input  logic [PC_W-1:0]  exe_redir_pc,
    input  logic             lsu_idle,
    output logic             icache_flush_req,
    input  logic             icache_flush_done,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [PC_W-1:0]  redir_pc,
    output logic             busy,
    output logic [CNT_W-1:0] flush_count
);

    flush_state_t     r_state;
    flush_state_t     w_next_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_redir_fire;

    assign w_accept     = exe_redir_valid && (r_state == ST_IDLE);
    assign w_redir_fire = (r_state == ST_REDIR) && redir_ready;

    // Flushes go high combinationally in the accept cycle so the pipeline
    // registers can drop their contents in that same cycle.
    assign exe_redir_ready  = (r_state == ST_IDLE);
    assign busy             = (r_state != ST_IDLE);
    assign flush_if_id      = w_accept || busy;
    assign flush_id_exe     = w_accept || busy;
    assign icache_flush_req = (r_state == ST_ICFLUSH);
    assign redir_valid      = (r_state == ST_REDIR);
    assign redir_pc         = r_pc;
    assign flush_count      = r_count;

    // State register; reset abandons any in-flight redirect at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. The request kind only matters at accept time: it is
    // folded into the state chosen there, so it is never stored separately.
    // The DRAIN exit looks at lsu_idle directly, so an LSU that is already
    // idle still costs one DRAIN cycle.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (exe_redir_kind == KIND_FENCEI) ? ST_DRAIN : ST_REDIR;
                end
            end
            ST_DRAIN: begin
                if (lsu_idle) begin
                    w_next_state = ICACHE_FLUSH_EN ? ST_ICFLUSH : ST_REDIR;
                end
            end
            ST_ICFLUSH: begin
                if (icache_flush_done) begin
                    w_next_state = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (redir_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Target captured at accept and held untouched until the IFU takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (w_accept) begin
            r_pc <= exe_redir_pc;
        end
    end

    // Completed-redirect counter, bumped on the IFU handshake; wraps freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_redir_fire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24100006_flush_ctrl
// Self-checking bench for the flush / redirect controller. Each transaction
// is described by its phase lengths (drain, I-cache flush, IFU backpressure)
// and the bench derives the expected per-cycle outputs from that timeline.
// A second instance with ICACHE_FLUSH_EN=0 covers the skipped-flush variant.
// ---------------------------------------------------------------------------
module tb_ysyx_24100006_flush_ctrl;
    import ysyx_24100006_flush_ctrl_pkg::*;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    // Timeline phases of one redirect, as seen from outside the block
    localparam int PH_IDLE    = 0;
    localparam int PH_ACCEPT  = 1;
    localparam int PH_DRAIN   = 2;
    localparam int PH_ICFLUSH = 3;
    localparam int PH_REDIR   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             exe_redir_valid;
    logic             exe_redir_valid0;
    logic [1:0]       exe_redir_kind;
    logic [PC_W-1:0]  exe_redir_pc;
    logic             lsu_idle;
    logic             icache_flush_done;
    logic             redir_ready;

    logic             exe_redir_ready,  exe_redir_ready0;
    logic             icache_flush_req, icache_flush_req0;
    logic             flush_if_id,      flush_if_id0;
    logic             flush_id_exe,     flush_id_exe0;
    logic             redir_valid,      redir_valid0;
    logic [PC_W-1:0]  redir_pc,         redir_pc0;
    logic             busy,             busy0;
    logic [CNT_W-1:0] flush_count,      flush_count0;

    logic [5:0] obs, obs0;
    assign obs  = {exe_redir_ready,  flush_if_id,  flush_id_exe,  busy,  redir_valid,  icache_flush_req};
    assign obs0 = {exe_redir_ready0, flush_if_id0, flush_id_exe0, busy0, redir_valid0, icache_flush_req0};

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] expCount = '0;

    ysyx_24100006_flush_ctrl #(.PC_W(PC_W), .ICACHE_FLUSH_EN(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .exe_redir_valid(exe_redir_valid), .exe_redir_ready(exe_redir_ready),
        .exe_redir_kind(exe_redir_kind), .exe_redir_pc(exe_redir_pc),
        .lsu_idle(lsu_idle),
        .icache_flush_req(icache_flush_req), .icache_flush_done(icache_flush_done),
        .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .busy(busy), .flush_count(flush_count)
    );

    ysyx_24100006_flush_ctrl #(.PC_W(PC_W), .ICACHE_FLUSH_EN(1'b0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset),
        .exe_redir_valid(exe_redir_valid0), .exe_redir_ready(exe_redir_ready0),
        .exe_redir_kind(exe_redir_kind), .exe_redir_pc(exe_redir_pc),
        .lsu_idle(lsu_idle),
        .icache_flush_req(icache_flush_req0), .icache_flush_done(icache_flush_done),
        .flush_if_id(flush_if_id0), .flush_id_exe(flush_id_exe0),
        .redir_valid(redir_valid0), .redir_ready(redir_ready), .redir_pc(redir_pc0),
        .busy(busy0), .flush_count(flush_count0)
    );

    always #5 clk = ~clk;

    // Expected {exe_redir_ready, flush_if_id, flush_id_exe, busy,
    // redir_valid, icache_flush_req} for a timeline phase.
    function automatic logic [5:0] expFlags(input int ph);
        logic rdy, fl, bsy, rv, req;
        rdy = (ph == PH_IDLE) || (ph == PH_ACCEPT);
        fl  = (ph != PH_IDLE);
        bsy = (ph != PH_IDLE) && (ph != PH_ACCEPT);
        rv  = (ph == PH_REDIR);
        req = (ph == PH_ICFLUSH);
        return {rdy, fl, fl, bsy, rv, req};
    endfunction

    // One redirect on the main instance. nLow: cycles lsu_idle stays low in
    // DRAIN; dWait: ICFLUSH cycles before done; rWait: REDIR cycles with
    // redir_ready low. With holdNext the next request is presented (and must
    // be ignored) for the whole busy period. Returns just after the final
    // handshake edge.
    task automatic runTxn(input logic [1:0] kind, input logic [PC_W-1:0] pc,
                          input int nLow, input int dWait, input int rWait,
                          input bit holdNext, input logic [1:0] nKind,
                          input logic [PC_W-1:0] nPc, input string tag);
        exe_redir_valid   = 1'b1;
        exe_redir_kind    = kind;
        exe_redir_pc      = pc;
        lsu_idle          = 1'($urandom);
        icache_flush_done = 1'($urandom);
        redir_ready       = 1'($urandom);
        @(negedge clk);
        checks++;
        if (obs !== expFlags(PH_ACCEPT)) begin
            errors++;
            $display("[TB] FAIL %s accept flags: got %b want %b", tag, obs, expFlags(PH_ACCEPT));
        end
        @(posedge clk); #1;

        exe_redir_valid = holdNext;
        exe_redir_kind  = holdNext ? nKind : 2'($urandom);
        exe_redir_pc    = holdNext ? nPc : PC_W'($urandom);

        if (kind == KIND_FENCEI) begin
            for (int j = 1; j <= nLow + 1; j++) begin
                lsu_idle          = (j == nLow + 1);
                icache_flush_done = 1'($urandom);
                redir_ready       = 1'($urandom);
                @(negedge clk);
                checks++;
                if (obs !== expFlags(PH_DRAIN)) begin
                    errors++;
                    $display("[TB] FAIL %s drain%0d flags: got %b want %b", tag, j, obs, expFlags(PH_DRAIN));
                end
                @(posedge clk); #1;
            end
            for (int j = 1; j <= dWait + 1; j++) begin
                icache_flush_done = (j == dWait + 1);
                lsu_idle          = 1'($urandom);
                redir_ready       = 1'($urandom);
                @(negedge clk);
                checks++;
                if (obs !== expFlags(PH_ICFLUSH)) begin
                    errors++;
                    $display("[TB] FAIL %s icflush%0d flags: got %b want %b", tag, j, obs, expFlags(PH_ICFLUSH));
                end
                @(posedge clk); #1;
            end
        end

        for (int j = 1; j <= rWait + 1; j++) begin
            redir_ready       = (j == rWait + 1);
            lsu_idle          = 1'($urandom);
            icache_flush_done = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== expFlags(PH_REDIR)) begin
                errors++;
                $display("[TB] FAIL %s redir%0d flags: got %b want %b", tag, j, obs, expFlags(PH_REDIR));
            end
            checks++;
            if (redir_pc !== pc) begin
                errors++;
                $display("[TB] FAIL %s redir%0d pc: got %h want %h", tag, j, redir_pc, pc);
            end
            checks++;
            if (flush_count !== expCount) begin
                errors++;
                $display("[TB] FAIL %s redir%0d count: got %0d want %0d", tag, j, flush_count, expCount);
            end
            @(posedge clk); #1;
        end
        expCount = expCount + 1'b1;
    endtask

    // One quiet cycle: controller must be idle with the expected count.
    task automatic checkIdle(input string tag);
        exe_redir_valid   = 1'b0;
        lsu_idle          = 1'($urandom);
        icache_flush_done = 1'($urandom);
        redir_ready       = 1'($urandom);
        @(negedge clk);
        checks++;
        if (obs !== expFlags(PH_IDLE)) begin
            errors++;
            $display("[TB] FAIL %s idle flags: got %b want %b", tag, obs, expFlags(PH_IDLE));
        end
        checks++;
        if (flush_count !== expCount) begin
            errors++;
            $display("[TB] FAIL %s idle count: got %0d want %0d", tag, flush_count, expCount);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        exe_redir_valid   = 1'b0;
        exe_redir_valid0  = 1'b0;
        exe_redir_kind    = 2'd0;
        exe_redir_pc      = '0;
        lsu_idle          = 1'b0;
        icache_flush_done = 1'b0;
        redir_ready       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 6'b100000 || redir_pc !== '0 || flush_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset main: got flags %b pc %h cnt %0d want 100000/0/0", obs, redir_pc, flush_count);
        end
        checks++;
        if (obs0 !== 6'b100000 || redir_pc0 !== '0 || flush_count0 !== '0) begin
            errors++;
            $display("[TB] FAIL reset noic: got flags %b pc %h cnt %0d want 100000/0/0", obs0, redir_pc0, flush_count0);
        end
        @(posedge clk); #1;
        reset    = 1'b0;
        expCount = '0;
        checkIdle("post_reset");
    endtask

    task automatic test_jump();
        runTxn(KIND_JUMP, 32'h8000_0100, 0, 0, 0, 1'b0, 2'd0, '0, "jump");
        checkIdle("jump");
    endtask

    task automatic test_backpressure();
        runTxn(KIND_TRAP, 32'h8000_0004, 0, 0, 3, 1'b0, 2'd0, '0, "backpressure");
        checkIdle("backpressure");
    endtask

    task automatic test_fencei();
        runTxn(KIND_FENCEI, 32'h8000_0010, 4, 1, 0, 1'b0, 2'd0, '0, "fencei");
        checkIdle("fencei");
    endtask

    task automatic test_back_to_back();
        runTxn(KIND_JUMP, 32'h8000_0300, 0, 0, 2, 1'b1, KIND_MRET, 32'h8000_0200, "busy_first");
        runTxn(KIND_MRET, 32'h8000_0200, 0, 0, 0, 1'b0, 2'd0, '0, "busy_second");
        checkIdle("busy");
    endtask

    // fence.i on the instance built without the I-cache flush phase
    task automatic test_no_icflush();
        logic sawReq;
        sawReq           = 1'b0;
        exe_redir_valid  = 1'b0;
        exe_redir_valid0 = 1'b1;
        exe_redir_kind   = KIND_FENCEI;
        exe_redir_pc     = 32'h8000_0080;
        lsu_idle         = 1'b1;
        redir_ready      = 1'b0;
        @(negedge clk);
        sawReq |= icache_flush_req0;
        checks++;
        if (obs0 !== expFlags(PH_ACCEPT)) begin
            errors++;
            $display("[TB] FAIL noic accept flags: got %b want %b", obs0, expFlags(PH_ACCEPT));
        end
        @(posedge clk); #1;
        exe_redir_valid0  = 1'b0;
        icache_flush_done = 1'b1;
        @(negedge clk);
        sawReq |= icache_flush_req0;
        checks++;
        if (obs0 !== expFlags(PH_DRAIN)) begin
            errors++;
            $display("[TB] FAIL noic drain flags: got %b want %b", obs0, expFlags(PH_DRAIN));
        end
        @(posedge clk); #1;
        icache_flush_done = 1'b0;
        redir_ready       = 1'b1;
        @(negedge clk);
        sawReq |= icache_flush_req0;
        checks++;
        if (obs0 !== expFlags(PH_REDIR) || redir_pc0 !== 32'h8000_0080) begin
            errors++;
            $display("[TB] FAIL noic redir T+2: got %b pc %h want %b pc 80000080", obs0, redir_pc0, expFlags(PH_REDIR));
        end
        @(posedge clk); #1;
        redir_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs0 !== expFlags(PH_IDLE) || flush_count0 !== 32'd1) begin
            errors++;
            $display("[TB] FAIL noic idle: got %b cnt %0d want %b cnt 1", obs0, flush_count0, expFlags(PH_IDLE));
        end
        checks++;
        if (sawReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL noic icache_flush_req: got %b want 0", sawReq);
        end
        @(posedge clk); #1;
        checkIdle("noic_main");
    endtask

    task automatic test_random();
        localparam int N = 30;
        logic [1:0]      kinds [N+1];
        logic [PC_W-1:0] pcs   [N+1];
        bit              b2b   [N+1];
        for (int i = 0; i <= N; i++) begin
            kinds[i] = 2'($urandom);
            pcs[i]   = {$urandom} & 32'hFFFF_FFFC;
            b2b[i]   = 1'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            bit hold;
            hold = b2b[i] && (i + 1 < N);
            runTxn(kinds[i], pcs[i], $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), hold, kinds[i+1], pcs[i+1], $sformatf("rand%0d", i));
            if (!hold) checkIdle($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_midflush();
        exe_redir_valid   = 1'b1;
        exe_redir_kind    = KIND_FENCEI;
        exe_redir_pc      = 32'h8000_0040;
        lsu_idle          = 1'b1;
        icache_flush_done = 1'b0;
        redir_ready       = 1'b0;
        @(posedge clk); #1;
        exe_redir_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== expFlags(PH_ICFLUSH)) begin
            errors++;
            $display("[TB] FAIL rst_mid icflush flags: got %b want %b", obs, expFlags(PH_ICFLUSH));
        end
        #1 reset = 1'b1;
        #1;
        expCount = '0;
        checks++;
        if (obs !== 6'b100000 || redir_pc !== '0 || flush_count !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid immediate: got flags %b pc %h cnt %0d want 100000/0/0", obs, redir_pc, flush_count);
        end
        @(posedge clk); #1;
        reset             = 1'b0;
        icache_flush_done = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== expFlags(PH_IDLE) || flush_count !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid stray done: got %b cnt %0d want %b cnt 0", obs, flush_count, expFlags(PH_IDLE));
        end
        @(posedge clk); #1;
        icache_flush_done = 1'b0;
        checkIdle("rst_mid");
        runTxn(KIND_JUMP, 32'h8000_0500, 0, 0, 1, 1'b0, 2'd0, '0, "rst_mid_after");
        checkIdle("rst_mid_after");
    endtask

    initial begin
        test_reset();
        test_jump();
        test_backpressure();
        test_fencei();
        test_back_to_back();
        test_no_icflush();
        test_random();
        test_reset_midflush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
